// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Pure combinational load-use compare between the EX load destination and the ID sources.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_valid,
  input  logic       i_ex_is_load,
  input  logic [4:0] i_ex_rd,
  output logic       o_load_use
);

  logic [4:0] w_src [2];
  logic [1:0] w_use;
  logic [1:0] w_hit;
  logic       w_load_live;

  assign w_src[0] = i_id_rs1;
  assign w_src[1] = i_id_rs2;
  assign w_use    = {i_id_use_rs2, i_id_use_rs1};

  // x0 is hardwired to zero, so a load targeting it never creates a real dependency.
  assign w_load_live = i_ex_valid & i_ex_is_load & (i_ex_rd != REG_ZERO);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign w_hit[gi] = w_use[gi] & (w_src[gi] == i_ex_rd);
    end
  endgenerate

  assign o_load_use = w_load_live & i_id_valid & (|w_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: stalls, bubbles, PC redirect FSM and perf counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [4:0]           ex_rd,
  input  logic                 branch_taken,
  input  logic                 if_busy,
  input  logic                 mem_busy,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 flush_wb,
  output logic                 pc_redirect,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  ctrl_state_e          r_state;
  ctrl_state_e          w_state_next;
  logic                 w_load_use;
  logic                 w_accept;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  hazard_detect u_hazard_detect (
    .i_id_valid   (id_valid),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .i_ex_valid   (ex_valid),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .o_load_use   (w_load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    flush_wb     = 1'b0;
    pc_redirect  = 1'b0;

    if (mem_busy) begin
      // Whole front end frozen; a branch in EX is simply re-evaluated later.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (r_state == ST_REDIRECT) begin
      pc_redirect = 1'b1;
      flush_id    = 1'b1;
      if (!if_busy) begin
        w_state_next = ST_RUN;
      end
    end else if (branch_taken) begin
      pc_redirect = 1'b1;
      flush_id    = 1'b1;
      flush_ex    = 1'b1;
      if (if_busy) begin
        w_state_next = ST_REDIRECT;
      end
    end else if (w_load_use) begin
      // Keeps the dependent instruction in ID even if a fetch is outstanding.
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end else if (if_busy) begin
      stall_if = 1'b1;
      flush_id = 1'b1;
    end
  end

  assign w_accept = pc_redirect & ~if_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_if) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_accept) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
